// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: UART transmitter with compile-time frame format (5-9 data bits,
// none/odd/even parity, 1-2 stop bits). Valid/ready input, registered line.
module uart_tx_cfg #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 busy,
    output logic                 tx_done
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_PRE  = CW'(CLKS_PER_BIT - 2);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);
    localparam logic STOP_LAST = (STOP_BITS == 2);

    generate
        if (CLKS_PER_BIT < 2 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
            STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_param
            $error("uart_tx_cfg: illegal parameter value");
        end
    endgenerate

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    state_t               state_q;
    logic [CW-1:0]        cnt_q;
    logic [IW-1:0]        idx_q;
    logic                 stop_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 par_q;
    logic                 tx_q;
    logic                 done_q;
    logic                 bit_end;

    assign bit_end  = cnt_q == CNT_LAST;
    assign tx_ready = state_q == IDLE;
    assign busy     = state_q != IDLE;
    assign tx       = tx_q;
    assign tx_done  = done_q;

    // tx_q always carries the level of the bit the state is entering, so the line
    // changes on the same edge as the state and stays glitch-free.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            stop_q  <= 1'b0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            cnt_q  <= (state_q == IDLE || bit_end) ? '0 : cnt_q + 1'b1;
            done_q <= state_q == STOP && stop_q == STOP_LAST && cnt_q == CNT_PRE;
            case (state_q)
                IDLE: if (tx_valid) begin
                    shift_q <= tx_data;
                    par_q   <= (^tx_data) ^ (PARITY == 1);
                    tx_q    <= 1'b0;
                    state_q <= START;
                end
                START: if (bit_end) begin
                    tx_q    <= shift_q[0];
                    idx_q   <= '0;
                    state_q <= DATA;
                end
                DATA: if (bit_end) begin
                    if (idx_q == IDX_LAST) begin
                        tx_q    <= (PARITY != 0) ? par_q : 1'b1;
                        stop_q  <= 1'b0;
                        state_q <= (PARITY != 0) ? PAR : STOP;
                    end else begin
                        shift_q <= shift_q >> 1;
                        tx_q    <= shift_q[1];
                        idx_q   <= idx_q + 1'b1;
                    end
                end
                PAR: if (bit_end) begin
                    tx_q    <= 1'b1;
                    stop_q  <= 1'b0;
                    state_q <= STOP;
                end
                STOP: if (bit_end) begin
                    stop_q  <= ~stop_q;
                    state_q <= (stop_q == STOP_LAST) ? IDLE : STOP;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
